disp_scaler: RTL

DISP_SCALER -- requirements
Module: disp_scaler

---
 rtl/disp_scaler.sv | 134 +++++++++++++
 1 files changed

// File: rtl/disp_scaler.sv
// Binary-to-BCD frequency display scaler: converts a binary Hz count with
// serial double-dabble, then picks a 4-digit Hz or kHz view with a decimal point.
module disp_scaler #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [4:0]       dig3,
  output logic [4:0]       dig2,
  output logic [4:0]       dig1,
  output logic [4:0]       dig0,
  output logic             khz,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SHIFT, SCALE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     bin_q, bin_d;
  logic [27:0]          bcd_q, bcd_d;
  logic [4:0]           cnt_q, cnt_d;
  logic [19:0]          digs_q, digs_d;
  logic                 khz_q, khz_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [27:0]          bcd_adj;
  logic [27+CNT_W:0]    shifted;
  logic [19:0]          scaled_digs;
  logic                 scaled_khz;

  // One double-dabble step: correct every nibble >= 5, then shift {bcd,bin}.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < 7; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
    shifted = {bcd_adj, bin_q} << 1;
  end

  // Window the four most significant digits; the dot marks the kHz units digit.
  always_comb begin
    scaled_khz  = 1'b1;
    scaled_digs = {1'b0, bcd_q[15:12], 1'b0, bcd_q[11:8],
                   1'b0, bcd_q[7:4],   1'b0, bcd_q[3:0]};
    if (bcd_q[27:24] != 4'd0) begin
      scaled_digs = {1'b0, bcd_q[27:24], 1'b0, bcd_q[23:20],
                     1'b0, bcd_q[19:16], 1'b1, bcd_q[15:12]};
    end else if (bcd_q[23:20] != 4'd0) begin
      scaled_digs = {1'b0, bcd_q[23:20], 1'b0, bcd_q[19:16],
                     1'b1, bcd_q[15:12], 1'b0, bcd_q[11:8]};
    end else if (bcd_q[19:16] != 4'd0) begin
      scaled_digs = {1'b0, bcd_q[19:16], 1'b1, bcd_q[15:12],
                     1'b0, bcd_q[11:8],  1'b0, bcd_q[7:4]};
    end else begin
      scaled_khz = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    digs_d  = digs_q;
    khz_d   = khz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d   = count;
          bcd_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = shifted[27+CNT_W:CNT_W];
        bin_d = shifted[CNT_W-1:0];
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(CNT_W - 1)) begin
          state_d = SCALE;
        end
      end
      SCALE: begin
        // Display registers only ever update here, so partial results never show.
        digs_d  = scaled_digs;
        khz_d   = scaled_khz;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      digs_q  <= '0;
      khz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      digs_q  <= digs_d;
      khz_q   <= khz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign dig3 = digs_q[19:15];
  assign dig2 = digs_q[14:10];
  assign dig1 = digs_q[9:5];
  assign dig0 = digs_q[4:0];
  assign khz  = khz_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
